// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding
// and the bit-counter width rule.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter must reach WIDTH, so it needs ceil(log2(WIDTH+1)) bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder assembled from two half adders and an OR gate.

module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1;
  logic c1;
  logic c2;

  halfadder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  halfadder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));

  assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor. Operands are captured on start, then one
// bit per clock runs through a single full-adder cell, LSB first. The
// result shifts into s from the MSB side, so after WIDTH edges s holds
// the full word. Subtraction is a + ~b + 1 (carry preset to 1).
// Handshake: start is sampled only in IDLE; busy is high in SHIFT;
// done is a one-cycle pulse with s/c/ovf valid in the same cycle, and
// those outputs hold until the next operation's first SHIFT edge.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   s,
  output logic               c,
  output logic               ovf,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t         state;
  state_t         state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           fa_sum;
  logic           fa_cout;
  logic           last_bit;

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .s    (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: IDLE waits for start, SHIFT runs WIDTH bits, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one full-adder step per SHIFT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c     <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          s     <= {fa_sum, s[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          // On the MSB step the incoming carry is the carry into the MSB.
          if (last_bit) begin
            c   <= fa_cout;
            ovf <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
